// File: rtl/frame_result_controller.sv
// frame_result_controller: confirms per-frame colour results over CONFIRM_FRAMES frames and sends each
// change of the stable result to the Arduino over a 4-phase REQ/ACK handshake. Define RESULT_TIMEOUT_EN to add an ACK timeout.
module frame_result_controller #(
   parameter int CONFIRM_FRAMES = 3,
   parameter int ACK_TIMEOUT    = 50000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       VGA_VSYNC_NEG,
   input  logic [1:0] FRAME_RESULT,
   input  logic       ARD_ACK,
   output logic       ARD_REQ,
   output logic [1:0] ARD_DATA,
   output logic [1:0] STABLE_RESULT,
   output logic       BUSY,
   output logic       TIMEOUT_ERR
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [3:0] CONFIRM_N  = 4'(CONFIRM_FRAMES);

   if (CONFIRM_FRAMES < 1 || CONFIRM_FRAMES > 15) begin : g_bad_confirm
      $error("CONFIRM_FRAMES must be 1..15");
   end
   if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_timeout
      $error("ACK_TIMEOUT must be 1..65535");
   end

   logic       vs_d_reg;
   logic       samp_stb_reg;
   logic       ack_meta_reg;
   logic       ack_s_reg;
   logic [1:0] cand_reg;
   logic [3:0] cnt_reg;
   logic [1:0] stable_reg;
   logic       pending_reg;
   logic [1:0] state_reg;
   logic       ard_req_reg;
   logic [1:0] ard_data_reg;
   logic       fall;
   logic [1:0] sample;
   logic       confirm;
   logic       launch;
   logic       tmo_abort;

   assign fall    = vs_d_reg & ~VGA_VSYNC_NEG;
   assign sample  = (FRAME_RESULT == 2'b11) ? 2'b00 : FRAME_RESULT;
   // cnt_reg already holds the post-strobe count, so confirm lands one edge after the strobe
   assign confirm = (cnt_reg == CONFIRM_N) && (cand_reg != stable_reg);
   assign launch  = (state_reg == ST_IDLE) && pending_reg;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vs_d_reg     <= 1'b0;
         samp_stb_reg <= 1'b0;
         ack_meta_reg <= 1'b0;
         ack_s_reg    <= 1'b0;
         cand_reg     <= 2'b00;
         cnt_reg      <= 4'd0;
         stable_reg   <= 2'b00;
         pending_reg  <= 1'b0;
      end else begin
         vs_d_reg     <= VGA_VSYNC_NEG;
         samp_stb_reg <= fall;
         ack_meta_reg <= ARD_ACK;
         ack_s_reg    <= ack_meta_reg;
         if (samp_stb_reg) begin
            if (sample == cand_reg) begin
               if (cnt_reg != CONFIRM_N) cnt_reg <= cnt_reg + 4'd1;
            end else begin
               cand_reg <= sample;
               cnt_reg  <= 4'd1;
            end
         end
         if (confirm) stable_reg <= cand_reg;
         // a confirm coinciding with a launch keeps pending set so the newer value follows
         if (confirm)     pending_reg <= 1'b1;
         else if (launch) pending_reg <= 1'b0;
      end
   end

`ifdef RESULT_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
   logic [15:0] tmo_cnt_reg;
   logic        timeout_err_reg;

   assign tmo_abort   = (state_reg == ST_SEND) && !ack_s_reg && (tmo_cnt_reg == TMO_LAST);
   assign TIMEOUT_ERR = timeout_err_reg;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tmo_cnt_reg     <= 16'd0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (launch)                      tmo_cnt_reg <= 16'd0;
         else if (state_reg == ST_SEND)   tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
         if (tmo_abort) timeout_err_reg <= 1'b1;
      end
   end
`else
   assign tmo_abort   = 1'b0;
   assign TIMEOUT_ERR = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg    <= ST_IDLE;
         ard_req_reg  <= 1'b0;
         ard_data_reg <= 2'b00;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pending_reg) begin
                  ard_data_reg <= stable_reg;
                  ard_req_reg  <= 1'b1;
                  state_reg    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (ack_s_reg) begin
                  ard_req_reg <= 1'b0;
                  state_reg   <= ST_RELEASE;
               end else if (tmo_abort) begin
                  ard_req_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            end
            ST_RELEASE: begin
               if (!ack_s_reg) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign ARD_REQ       = ard_req_reg;
   assign ARD_DATA      = ard_data_reg;
   assign STABLE_RESULT = stable_reg;
   assign BUSY          = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_frame_result_controller.sv
// Bench for frame_result_controller: frame-level reference model plus a randomly delayed Arduino responder.
`timescale 1ns/1ps
module tb_frame_result_controller;
   localparam int CF = 3;
`ifdef RESULT_TIMEOUT_EN
   localparam int TMO = 20;
`else
   localparam int TMO = 50000;
`endif

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       VGA_VSYNC_NEG = 1'b1;
   logic [1:0] FRAME_RESULT = 2'b00;
   logic       ARD_ACK = 1'b0;
   logic       ARD_REQ;
   logic [1:0] ARD_DATA;
   logic [1:0] STABLE_RESULT;
   logic       BUSY;
   logic       TIMEOUT_ERR;

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_xfer = 0;
   bit         ack_en = 1'b1;
   logic       req_prev = 1'b0;
   logic [1:0] hist[$];
   logic [1:0] exp_q[$];
   logic [1:0] rx_q[$];
   logic [1:0] model_stable = 2'b00;

   frame_result_controller #(.CONFIRM_FRAMES(CF), .ACK_TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .VGA_VSYNC_NEG(VGA_VSYNC_NEG), .FRAME_RESULT(FRAME_RESULT),
      .ARD_ACK(ARD_ACK), .ARD_REQ(ARD_REQ), .ARD_DATA(ARD_DATA), .STABLE_RESULT(STABLE_RESULT),
      .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: stable result changes when the last CF mapped frames all agree on a new value
   task automatic model_frame(input logic [1:0] v);
      logic [1:0] m;
      bit same;
      m = (v == 2'b11) ? 2'b00 : v;
      hist.push_back(m);
      if (hist.size() > CF) void'(hist.pop_front());
      same = (hist.size() == CF);
      foreach (hist[i]) if (hist[i] != m) same = 1'b0;
      if (same && m != model_stable) begin
         model_stable = m;
         exp_q.push_back(m);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_frame(input logic [1:0] v, input bit lat);
      FRAME_RESULT  = v;
      VGA_VSYNC_NEG = 1'b0;
      model_frame(v);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         if (lat) check_eq("req_latency", int'(ARD_REQ), int'(k == 4));
      end
      VGA_VSYNC_NEG = 1'b1;
      tick(36);
      check_eq("stable", int'(STABLE_RESULT), int'(model_stable));
   endtask

   function automatic int rx_at(input int i);
      return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
   endfunction

   // Arduino responder: acknowledges a request and releases after random delays
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         if (ack_en && ARD_REQ && !ARD_ACK) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #2;
            ARD_ACK = 1'b1;
         end else if (!ARD_REQ && ARD_ACK) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #2;
            ARD_ACK = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (ARD_REQ && !req_prev) begin
         rx_q.push_back(ARD_DATA);
         n_xfer++;
         $display("xfer %0d data=%b t=%0t", n_xfer, ARD_DATA, $time);
      end else if (ARD_REQ && rx_q.size() > 0) begin
         check_eq("data_hold", int'(ARD_DATA), int'(rx_q[$]));
      end
      req_prev <= ARD_REQ;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] v;
      int run;
      int nfr;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_req", int'(ARD_REQ), 0);
      check_eq("rst_data", int'(ARD_DATA), 0);
      check_eq("rst_stable", int'(STABLE_RESULT), 0);
      check_eq("rst_busy", int'(BUSY), 0);
      check_eq("rst_tmo", int'(TIMEOUT_ERR), 0);
      RESET_N = 1'b1;
      tick(5);

      // five frames of red, latency measured on the confirming frame
      rx_q.delete();
      for (int i = 1; i <= 5; i++) send_frame(2'b01, i == 3);
      check_eq("t1_count", rx_q.size(), 1);
      check_eq("t1_data", rx_at(0), 1);

      // a single odd frame restarts the confirmation count
      rx_q.delete();
      send_frame(2'b10, 0);
      send_frame(2'b10, 0);
      send_frame(2'b01, 0);
      send_frame(2'b10, 0);
      send_frame(2'b10, 0);
      check_eq("t2_none_yet", rx_q.size(), 0);
      send_frame(2'b10, 0);
      check_eq("t2_count", rx_q.size(), 1);
      check_eq("t2_data", rx_at(0), 2);

      // changes during a stalled transfer coalesce into one follow-up transfer
      rx_q.delete();
      ack_en = 1'b0;
      repeat (3) send_frame(2'b01, 0);
      repeat (3) send_frame(2'b10, 0);
      repeat (3) send_frame(2'b00, 0);
      check_eq("t3_req_held", int'(ARD_REQ), 1);
      check_eq("t3_busy_held", int'(BUSY), 1);
      check_eq("t3_count_held", rx_q.size(), 1);
      ack_en = 1'b1;
      tick(60);
      check_eq("t3_count", rx_q.size(), 2);
      check_eq("t3_first", rx_at(0), 1);
      check_eq("t3_second", rx_at(1), 0);
      check_eq("t3_busy_done", int'(BUSY), 0);

      // illegal code is treated as none
      rx_q.delete();
      repeat (3) send_frame(2'b01, 0);
      repeat (3) send_frame(2'b11, 0);
      check_eq("t4_count", rx_q.size(), 2);
      check_eq("t4_data", rx_at(1), 0);

      // randomized runs of frame values
      rx_q.delete();
      exp_q.delete();
      nfr = 0;
      while (nfr < 45) begin
         v = 2'($urandom_range(0, 3));
         run = $urandom_range(1, 4);
         for (int r = 0; r < run; r++) send_frame(v, 0);
         nfr += run;
      end
      tick(60);
      check_eq("rand_count", rx_q.size(), exp_q.size());
      foreach (exp_q[i]) check_eq("rand_data", rx_at(i), int'(exp_q[i]));

      // reset asserted while a request is outstanding
      ack_en = 1'b0;
      v = (model_stable == 2'b01) ? 2'b10 : 2'b01;
      repeat (3) send_frame(v, 0);
      check_eq("t5_req_before", int'(ARD_REQ), 1);
      #3;
      RESET_N = 1'b0;
      #1;
      check_eq("t5_req", int'(ARD_REQ), 0);
      check_eq("t5_data", int'(ARD_DATA), 0);
      check_eq("t5_stable", int'(STABLE_RESULT), 0);
      check_eq("t5_busy", int'(BUSY), 0);
      check_eq("t5_tmo", int'(TIMEOUT_ERR), 0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      hist.delete();
      model_stable = 2'b00;
      rx_q.delete();
      ack_en = 1'b1;
      repeat (3) send_frame(2'b00, 0);
      check_eq("t5_no_req", rx_q.size(), 0);

`ifdef RESULT_TIMEOUT_EN
      // request never acknowledged: abort after TMO cycles, error flag sticks
      ack_en = 1'b0;
      repeat (2) send_frame(2'b01, 0);
      FRAME_RESULT  = 2'b01;
      VGA_VSYNC_NEG = 1'b0;
      model_frame(2'b01);
      tick(4);
      check_eq("tmo_rise", int'(ARD_REQ), 1);
      VGA_VSYNC_NEG = 1'b1;
      tick(TMO - 1);
      check_eq("tmo_still_req", int'(ARD_REQ), 1);
      check_eq("tmo_err_early", int'(TIMEOUT_ERR), 0);
      tick(1);
      check_eq("tmo_req_clr", int'(ARD_REQ), 0);
      check_eq("tmo_err", int'(TIMEOUT_ERR), 1);
      check_eq("tmo_busy", int'(BUSY), 0);
      tick(20);
      check_eq("tmo_stable", int'(STABLE_RESULT), 1);
      ack_en = 1'b1;
      rx_q.delete();
      repeat (3) send_frame(2'b10, 0);
      check_eq("tmo_next_count", rx_q.size(), 1);
      check_eq("tmo_next_data", rx_at(0), 2);
      check_eq("tmo_err_sticky", int'(TIMEOUT_ERR), 1);
`else
      check_eq("tmo_err_off", int'(TIMEOUT_ERR), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_result_controller.md
# frame_result_controller

Sequences per-frame colour classifications from the image processor and delivers them to the Arduino. At each frame boundary, marked by the falling edge of VGA_VSYNC_NEG, it samples the 2-bit frame result and requires CONFIRM_FRAMES consecutive identical samples before it accepts a new stable result. Every change of the stable result is sent over a 4-phase REQ/ACK handshake on a 2-bit parallel bus. The block sits between the image processor's RESULT output and the FPGA-to-Arduino GPIO pins.

## Interface
- CONFIRM_FRAMES, default 3: consecutive matching frames needed to accept a result (legal range 1..15).
- ACK_TIMEOUT, default 50000: cycles REQ may stay unacknowledged before abort (used only with RESULT_TIMEOUT_EN; legal range 1..65535).
- CLK  in  1  system/pixel clock; all logic on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- VGA_VSYNC_NEG  in  1  frame sync, synchronous to CLK; falling edge marks end of frame.
- FRAME_RESULT  in  2  image-processor classification: 00 none, 01 red, 10 blue, 11 illegal.
- ARD_ACK  in  1  Arduino acknowledge; asynchronous, passed through a 2-flop synchronizer.
- ARD_REQ  out  1  data-valid request to the Arduino.
- ARD_DATA  out  2  result being sent; held stable while ARD_REQ=1.
- STABLE_RESULT  out  2  last confirmed result.
- BUSY  out  1  high when the FSM is not IDLE.
- TIMEOUT_ERR  out  1  sticky abort flag; constant 0 without RESULT_TIMEOUT_EN.

## Operation
- Frame strobe: vs_d is VGA_VSYNC_NEG registered. fall = vs_d & ~VGA_VSYNC_NEG. fall is registered once more into samp_stb.
- On samp_stb:
  - An input of 11 is mapped to 00.
  - If the input equals cand, cnt increments, saturating at CONFIRM_FRAMES.
  - Otherwise cand takes the input and cnt is set to 1.
- Confirm: when the updated cnt equals CONFIRM_FRAMES and cand differs from STABLE_RESULT, STABLE_RESULT takes cand on the next edge and the pending flag is set.
- Handshake FSM:
  - IDLE: if pending, load ARD_DATA from STABLE_RESULT, set ARD_REQ, clear pending, and go to SEND.
  - SEND: on ack_s=1, clear ARD_REQ and go to RELEASE.
  - RELEASE: on ack_s=0, go to IDLE.
- Coalescing: pending is a single flag. If STABLE_RESULT changes one or more times during a transfer, exactly one more transfer follows, carrying the value current at launch.
- An ack_s already high while in IDLE is ignored until the next SEND.
- Reset values: ARD_REQ=0, ARD_DATA=00, STABLE_RESULT=00, BUSY=0, TIMEOUT_ERR=0, cand=00, cnt=0, pending=0, FSM=IDLE, sync flops=0.
- Because STABLE_RESULT resets to 00, frames of 00 after reset never trigger a transfer.
- Asserting RESET_N low mid-transfer drops ARD_REQ immediately and asynchronously; the interrupted value is lost.

## Timing
- E0: the edge at which fall is first true.
- E1: samp_stb high; cand and cnt updated.
- E2: STABLE_RESULT and pending updated.
- E3: ARD_REQ=1 with ARD_DATA valid, provided the FSM was IDLE.
- Frame-result-to-REQ latency is therefore 3 cycles after E0 on the confirming frame.
- ARD_ACK rising is seen 2 edges after it changes; REQ falls on the following edge, 3 edges after the ACK change. The release phase has the same latency.
- Simultaneous events:
  - A confirm on the same edge the FSM returns to IDLE is launched on the next edge.
  - fall occurring while samp_stb is high is processed normally; each strobe is a separate frame.
- cnt width is 4 bits. Timeout counter width is 16 bits.

## Configuration
- RESULT_TIMEOUT_EN defined:
  - In SEND, a 16-bit counter increments each cycle.
  - When it reaches ACK_TIMEOUT with ack_s still 0, ARD_REQ clears, TIMEOUT_ERR sets (sticky until reset), and the FSM goes to IDLE.
  - pending is left unchanged, so a newer result is still sent.
  - The counter clears on entering SEND.
- RESULT_TIMEOUT_EN undefined: SEND waits indefinitely, no timeout counter is synthesized, and TIMEOUT_ERR is tied to 0.

## Test plan
- Reset, then 5 frames of 01 with CONFIRM_FRAMES=3 and ACK tied to follow REQ: STABLE_RESULT=01 after frame 3; exactly one transfer with ARD_DATA=01; ARD_REQ rises 3 cycles after the third VSYNC fall.
- Frame sequence 10,10,01,10,10,10: no transfer until the 6th frame, then a single transfer of 10 (the 01 frame restarts cnt).
- ACK held low while STABLE_RESULT goes 01, then 10, then 00: the first transfer carries 01; after ACK completes, exactly one further transfer carries 00.
- FRAME_RESULT=11 for 3 frames after STABLE_RESULT=01: treated as 00; STABLE_RESULT=00 and a transfer of 00 occurs.
- RESET_N pulsed low while ARD_REQ=1: ARD_REQ drops within the reset pulse, all outputs return to reset values, and there is no REQ after release until a new confirm.
- With RESULT_TIMEOUT_EN and ACK_TIMEOUT=20, ACK never asserted: ARD_REQ clears 20 cycles after rising, TIMEOUT_ERR=1 and stays 1, BUSY=0.
